// File: rtl/fsm_seq_driver.sv
// Sequencer for the 10-state Moore pattern FSM: resets the FSM, shifts a stored
// pattern into its x input one bit per clock, records y after every bit and
// counts the y=1 hits, then pulses done for one cycle.
module fsm_seq_driver #(
  parameter int unsigned PAT_W = 16,
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] hit_count_o,
  output logic [PAT_W-1:0] y_trace_o,
  output logic             fsm_rst_o,
  output logic             fsm_x_o,
  input  logic             fsm_y_i
);

  localparam logic [LEN_W-1:0] One    = LEN_W'(1);
  localparam logic [LEN_W-1:0] PatLen = LEN_W'(PAT_W);

  typedef enum logic [2:0] {
    StIdle,
    StReset,
    StRun,
    StTail,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] shift_q, shift_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] eff_len_q, eff_len_d;
  logic [LEN_W-1:0] hit_q, hit_d;
  logic [PAT_W-1:0] trace_q, trace_d;

  logic             sample;
  logic [LEN_W-1:0] idx;

  // Next-state logic; y seen during RUN cycle k belongs to bit k-1, TAIL closes the last bit.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    eff_len_d = eff_len_q;
    hit_d     = hit_q;
    trace_d   = trace_q;
    sample    = 1'b0;
    idx       = '0;

    case (state_q)
      StIdle: begin
        if (start_i && (len_i != '0)) begin
          shift_d   = pattern_i;
          eff_len_d = (len_i > PatLen) ? PatLen : len_i;
          hit_d     = '0;
          trace_d   = '0;
          cnt_d     = '0;
          state_d   = StReset;
        end
      end
      StReset: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        shift_d = {1'b0, shift_q[PAT_W-1:1]};
        if (cnt_q != '0) begin
          sample = 1'b1;
          idx    = cnt_q - One;
        end
        if (cnt_q == (eff_len_q - One)) begin
          state_d = StTail;
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      StTail: begin
        sample  = 1'b1;
        idx     = eff_len_q - One;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (sample) begin
      hit_d = hit_q + {{(LEN_W-1){1'b0}}, fsm_y_i};
      for (int unsigned i = 0; i < PAT_W; i++) begin
        if (LEN_W'(i) == idx) begin
          trace_d[i] = fsm_y_i;
        end
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      cnt_q     <= '0;
      eff_len_q <= '0;
      hit_q     <= '0;
      trace_q   <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      eff_len_q <= eff_len_d;
      hit_q     <= hit_d;
      trace_q   <= trace_d;
    end
  end

  // Outputs decoded from the current state; FSM reset follows system reset combinationally.
  always_comb begin
    busy_o      = (state_q == StReset) || (state_q == StRun) || (state_q == StTail);
    done_o      = (state_q == StDone);
    hit_count_o = hit_q;
    y_trace_o   = trace_q;
    fsm_rst_o   = rst_i || (state_q == StReset);
    fsm_x_o     = (state_q == StRun) ? shift_q[0] : 1'b0;
  end

endmodule

// File: doc/fsm_seq_driver.md
Name: fsm_seq_driver

Overview:
Controller that sequences the team's 10-state Moore pattern FSM (ports x, rst, clk in; y out).
- On a start request it resets the FSM, then shifts a stored bit pattern into the FSM's x input, one bit per clock.
- It captures the FSM's y response after every bit and counts y=1 hits.
- It reports completion with a one-cycle done pulse.
- It sits between the lab test harness (switches/buttons or testbench) and the FSM instance.

Parameters:
PAT_W, 16, maximum pattern length in bits; also the y_trace width.
LEN_W, 5, width of len and hit_count; must satisfy 2^LEN_W > PAT_W.

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  request a run; sampled only in IDLE
pattern  input  PAT_W  bits to drive; pattern[0] is driven first
len  input  LEN_W  number of bits to drive; 0 = no run; values above PAT_W are clamped to PAT_W
busy  output  1  high from the cycle after start is accepted until done clears
done  output  1  one-cycle pulse when results are valid
hit_count  output  LEN_W  number of y=1 samples in the last run
y_trace  output  PAT_W  y_trace[k] = FSM y after bit k; bits at or above len are 0
fsm_rst  output  1  to FSM rst; combinational = rst OR (state==RESET)
fsm_x  output  1  to FSM x; combinational = shift_reg[0] in RUN, else 0
fsm_y  input  1  from FSM y (Moore output of FSM state)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, busy=0, done=0, hit_count=0, y_trace=0, shift_reg=0, bit counter=0. fsm_rst is high during any cycle with rst=1. Reset mid-run aborts immediately with no done pulse.
- States: IDLE, RESET, RUN, TAIL, DONE.
- IDLE: on start=1 with len!=0:
  - latch pattern into shift_reg;
  - latch eff_len = min(len, PAT_W);
  - clear hit_count and y_trace;
  - go to RESET.
- IDLE, other inputs: start=1 with len=0 is ignored (no state change, no done).
- RESET: one cycle; fsm_rst=1, fsm_x=0. The FSM enters S0 at the ending edge. Next state is RUN with bit index k=0.
- RUN, cycle k (k = 0 .. eff_len-1):
  - fsm_x = shift_reg[0]; at the ending edge, shift_reg shifts right by 1 (zero fill).
  - For k >= 1, the sequencer samples fsm_y into y_trace[k-1] and adds it to hit_count (this y reflects bits 0..k-1).
  - After k = eff_len-1, go to TAIL.
- TAIL: one cycle; fsm_x=0. Sample fsm_y into y_trace[eff_len-1] and add it to hit_count. Go to DONE. The FSM still advances on x=0; this is harmless because the result is already captured.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE and IDLE; busy=1 in RESET, RUN and TAIL.
- Latency: if start is sampled at edge E, done is high in the cycle following edge E+eff_len+2.
- Results: hit_count and y_trace hold their values until the next accepted start. They are not cleared on done.
- start while busy: ignored, including start held high across DONE. A new run needs start sampled in IDLE; a held-high start restarts on the cycle after DONE.
- hit_count width: cannot overflow, since the maximum is PAT_W < 2^LEN_W.
- Arithmetic: all unsigned; the bit index is a LEN_W-bit counter compared against eff_len-1.

Test Plan:
- pattern=16'h0009, len=4 (bits 1,0,0,1 → FSM S1,S2,S3,S4) -> y_trace=16'h0008, hit_count=1, done pulses exactly 6 cycles after the start edge; fsm_x sequence 1,0,0,1 in RUN.
- pattern=16'h0004, len=3 (bits 0,0,1 → S5,S8,S9) -> y_trace=16'h0004, hit_count=1.
- pattern=16'h00A5, len=8 (bits 1,0,1,0,0,1,0,1 → S1,S2,S6,S7,S8,S9,S7,S6) -> y_trace=16'h0068, hit_count=3.
- len=0 with start=1 -> stays IDLE, busy=0, no done; len=20 with pattern=16'h0000 -> runs 16 bits, hit_count=0, y_trace=0, done after 18 cycles.
- rst asserted on the third RUN cycle -> next cycle busy=0, done=0, hit_count=0, y_trace=0, fsm_rst=1 during the rst cycle, no done pulse. start pulsed during RUN -> ignored, run completes with unchanged results.
- Two back-to-back runs (start held high) -> second run begins the cycle after DONE; FSM is re-reset (fsm_rst=1 one cycle) and results reflect only the second pattern.
